// File: rtl/port_link_pkg.sv
// Shared types and constants for the CPU port link peer: FSM encoding,
// exchange grouping and the byte bit-slice map.
package port_link_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_STALL = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int unsigned EXCH_PER_BYTE = 3;
  localparam logic [1:0]  IDX_LAST      = 2'(EXCH_PER_BYTE - 1);

  localparam int unsigned EX0_LSB = 0;
  localparam int unsigned EX1_LSB = 3;
  localparam int unsigned EX2_LSB = 6;

  // Reply nibble payload for a given exchange index; ex2 carries the tx flag on top.
  function automatic logic [2:0] tx_field(input logic [7:0] tx, input logic flag,
                                          input logic [1:0] idx);
    logic [2:0] f;
    case (idx)
      2'd0:    f = tx[EX0_LSB +: 3];
      2'd1:    f = tx[EX1_LSB +: 3];
      default: f = {flag, tx[EX2_LSB +: 2]};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/port_link_peer_if.sv
// Bundle of the CPU-port and host-side byte handshake signals of port_link_peer.
interface port_link_peer_if;
  logic [3:0] port_output;
  logic [3:0] port_input;
  logic [7:0] out_rx_data;
  logic       out_rx_valid;
  logic       in_rx_ready;
  logic [7:0] in_tx_data;
  logic       in_tx_valid;
  logic       out_tx_ready;

  // master: CPU and host side driving the peer
  modport master (
    output port_output, in_rx_ready, in_tx_data, in_tx_valid,
    input  port_input, out_rx_data, out_rx_valid, out_tx_ready
  );

  // slave: the peer itself
  modport slave (
    input  port_output, in_rx_ready, in_tx_data, in_tx_valid,
    output port_input, out_rx_data, out_rx_valid, out_tx_ready
  );
endinterface

// File: rtl/port_link_peer_sync.sv
// SYNC_STAGES-deep 4-bit synchronizer for the CPU port, reset to zero.
module port_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  logic [3:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/port_link_peer.sv
// Peer end of a toggle-handshake 4-bit CPU port: assembles bytes from three
// 3-bit exchanges and returns a host byte in the reply nibbles.
module port_link_peer
  import port_link_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] port_output,
  output logic [3:0] port_input,
  output logic [7:0] out_rx_data,
  output logic       out_rx_valid,
  input  logic       in_rx_ready,
  input  logic [7:0] in_tx_data,
  input  logic       in_tx_valid,
  output logic       out_tx_ready
);

  logic [3:0] sync_w;
  logic       req_w;
  logic [2:0] d_w;

  port_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (port_output),
    .dout_o (sync_w)
  );

  assign req_w = sync_w[3];
  assign d_w   = sync_w[2:0];

  state_e     state_q;
  logic       ack_q;
  logic [1:0] idx_q;
  logic [2:0] d_q;
  logic [2:0] r_q;
  logic [5:0] rx_buf_q;
  logic [7:0] tx_q;
  logic       tx_flag_q;
  logic [3:0] port_input_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;

  logic       pending_w;
  logic       take_tx_w;
  logic [7:0] tx_snap_w;

  assign pending_w = (req_w != ack_q);
  assign tx_snap_w = in_tx_valid ? in_tx_data : '0;
  // Consumption is signalled in the very cycle the snapshot is taken.
  assign take_tx_w = (state_q == ST_WAIT) && pending_w && (idx_q == 2'd0) && in_tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT;
      ack_q        <= 1'b0;
      idx_q        <= '0;
      d_q          <= '0;
      r_q          <= '0;
      rx_buf_q     <= '0;
      tx_q         <= '0;
      tx_flag_q    <= 1'b0;
      port_input_q <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      if (rx_valid_q && in_rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        ST_WAIT: begin
          if (pending_w) begin
            d_q <= d_w;
            if (idx_q == 2'd0) begin
              tx_q      <= tx_snap_w;
              tx_flag_q <= in_tx_valid;
              r_q       <= tx_snap_w[EX0_LSB +: 3];
            end else begin
              r_q <= tx_field(tx_q, tx_flag_q, idx_q);
            end
            // A committing ex2 must wait until the previous byte is drained.
            if ((idx_q == IDX_LAST) && d_w[2] && rx_valid_q) state_q <= ST_STALL;
            else                                             state_q <= ST_ACK;
          end
        end

        ST_STALL: begin
          if (!rx_valid_q) state_q <= ST_ACK;
        end

        ST_ACK: begin
          port_input_q <= {~ack_q, r_q};
          ack_q        <= ~ack_q;
          idx_q        <= (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
          case (idx_q)
            2'd0:    rx_buf_q[EX0_LSB +: 3] <= d_q;
            2'd1:    rx_buf_q[EX1_LSB +: 3] <= d_q;
            default: begin
              if (d_q[2]) begin
                rx_data_q  <= {d_q[1:0], rx_buf_q};
                rx_valid_q <= 1'b1;
              end
            end
          endcase
          state_q <= ST_WAIT;
        end

        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign port_input   = port_input_q;
  assign out_rx_data  = rx_data_q;
  assign out_rx_valid = rx_valid_q;
  assign out_tx_ready = take_tx_w;

endmodule

// File: doc/port_link_peer.md
PORT_LINK_PEER -- requirements
Module: port_link_peer

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, flop stages on the port_output sample path (min 1).
REQ-002 SHALL have port: clk  input  1  single clock for all state.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: port_output  input  4  CPU port; bit3 = req toggle, bits[2:0] = CPU->peer data.
REQ-005 SHALL have port: port_input  output  4  to CPU port; bit3 = ack toggle, bits[2:0] = peer->CPU data.
REQ-006 SHALL have port: out_rx_data  output  8  byte received from CPU.
REQ-007 SHALL have port: out_rx_valid  output  1  out_rx_data holds an unconsumed byte.
REQ-008 SHALL have port: in_rx_ready  input  1  host accepts byte; transfer when valid&&ready.
REQ-009 SHALL have port: in_tx_data  input  8  byte offered to CPU.
REQ-010 SHALL have port: in_tx_valid  input  1  in_tx_data is valid.
REQ-011 SHALL have port: out_tx_ready  output  1  one-cycle pulse: in_tx_data consumed this cycle.

Function
REQ-012 SHALL treat an exchange as pending when synchronized req (port_output[3]) differs from the internal ack bit.
REQ-013 SHALL group exchanges in threes via index idx 0->1->2->0; byte map: ex0 d[2:0]->byte[2:0], ex1 d[2:0]->byte[5:3], ex2 d[1:0]->byte[7:6], ex2 d[2] = commit flag.
REQ-014 SHALL implement FSM states WAIT, STALL, ACK; WAIT->ACK on pending (latch d, prepare r), except idx==2 with commit=1 and out_rx_valid=1 -> STALL; STALL->ACK when out_rx_valid is 0; ACK->WAIT always.
REQ-015 SHALL in ACK register port_input = {~ack, r}, toggle ack, and advance idx modulo 3.
REQ-016 SHALL, when no stall, update port_input exactly SYNC_STAGES+2 clock edges after the edge on which port_output toggled.
REQ-017 SHALL at the ACK of idx==2 with commit=1 load out_rx_data with the assembled byte and set out_rx_valid; with commit=0 (poll) produce no rx byte.
REQ-018 SHALL clear out_rx_valid on valid&&ready; a same-cycle load (REQ-017) takes priority and leaves out_rx_valid set.
REQ-019 SHALL at WAIT->ACK with idx==0 snapshot in_tx_data if in_tx_valid, pulse out_tx_ready that cycle, and set tx flag; else tx byte = 0 and flag = 0.
REQ-020 SHALL return r: ex0 = tx[2:0], ex1 = tx[5:3], ex2 = {flag, tx[7:6]}.
REQ-021 SHALL not accept a new exchange while in ACK or STALL; CPU holds req/data stable until ack matches.
REQ-022 SHALL hold port_input unchanged between ACKs.

Reset
REQ-023 SHALL on rst_n low asynchronously force: port_input=4'h0, ack=0, idx=0, state=WAIT, out_rx_data=8'h00, out_rx_valid=0, out_tx_ready=0, tx flag=0, synchronizer flops=0.
REQ-024 SHALL abandon any partial byte on reset; after release a req=1 is taken as a fresh ex0.

Structure
REQ-025 SHALL place FSM state encoding, EXCH_PER_BYTE=3 and byte bit-slice constants in shared package port_link_pkg.
REQ-026 SHALL instantiate one sub-module port_sync (SYNC_STAGES-deep 4-bit synchronizer, reset to 0).

Verification
REQ-027 SHALL cover rx: exchanges d=5,4,6 (commit) -> out_rx_data=8'hA5, out_rx_valid=1 after third ACK.
REQ-028 SHALL cover tx: in_tx_data=8'h3C valid before ex0 -> out_tx_ready one pulse, r=4,7,4 (flag=1).
REQ-029 SHALL cover stall: rx byte held (in_rx_ready=0), second byte's third exchange -> no ack toggle until in_rx_ready=1, then out_rx_data updates.
REQ-030 SHALL cover poll: ex2 d=3'b010 -> out_rx_valid stays 0; with in_tx_valid=0 -> r=0,0,0.
REQ-031 SHALL cover reset mid-byte: rst_n low after ex1 -> port_input=4'h0, idx=0; next three exchanges d=1,0,4 -> out_rx_data=8'h01.
REQ-032 SHALL cover latency: SYNC_STAGES=2, req toggle -> port_input[3] toggles exactly 4 edges later.
